// File: rtl/mem_bus_pkg.sv
// Shared definitions for the uniBus memory master: op encodings, width defaults, FSM states.
package mem_bus_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT = 8;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 7.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WHOLD,
        RWAIT,
        TURN
    } mbm_state_t;

endpackage

// File: rtl/mem_bus_tristate.sv
// uniBus pad: drives write data while enabled, floats otherwise, and returns the bus value.
module mem_bus_tristate #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              bus_oe_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    inout  wire  [DATA_W-1:0] bus_io
);

    assign bus_io  = bus_oe_i ? wdata_i : {DATA_W{1'bz}};
    assign rdata_o = bus_io;

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the shared 8-bit uniBus memory protocol. One request in flight at a time.
// Optional build macro MEM_BUS_STATS_EN adds per-type completion counters.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_run,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
`ifdef MEM_BUS_STATS_EN
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
`endif
    inout  wire  [DATA_W-1:0] uniBus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    mbm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              mem_run_q, mem_run_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0] rdata_in;

    mem_bus_tristate #(
        .DATA_W (DATA_W)
    ) u_tristate (
        .bus_oe_i (bus_oe_q),
        .wdata_i  (wdata_q),
        .rdata_o  (rdata_in),
        .bus_io   (uniBus)
    );

    // Next state, latched request fields, and registered outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = CMD;
                    mem_rw_d   = req_rw;
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                end
            end
            CMD: begin
                if (mem_rw_q == RW_WRITE) begin
                    state_d = WHOLD;
                end else begin
                    state_d = RWAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WHOLD: state_d = IDLE;
            RWAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_rdata_d = rdata_in;
                    state_d     = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        mem_run_d   = (state_d == CMD);
        // Write data is driven in CMD and held through WHOLD so memory samples a stable bus.
        bus_oe_d    = ((state_d == CMD) && (mem_rw_d == RW_WRITE)) || (state_d == WHOLD);
        rsp_valid_d = (state_d == WHOLD) || (state_d == TURN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_run_q   <= 1'b0;
            mem_rw_q    <= RW_READ;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            bus_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_run_q   <= mem_run_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            bus_oe_q    <= bus_oe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = ~req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_run   = mem_run_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;

`ifdef MEM_BUS_STATS_EN
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_wr_q, stat_wr_d;

    // Count completions by type; mem_rw_q still holds the finishing op during its response cycle.
    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (rsp_valid_q && (mem_rw_q == RW_READ)) begin
            stat_rd_d = stat_rd_q + 16'd1;
        end
        if (rsp_valid_q && (mem_rw_q == RW_WRITE)) begin
            stat_wr_d = stat_wr_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset, wrapping naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: scoreboard of expected responses, a memory responder
// model on uniBus, and a second instance (READ_LATENCY=3) for reset during a read.
`timescale 1ns/1ps
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int unsigned RL  = 1;
    localparam int unsigned RL3 = 3;
    localparam logic [7:0] PROBE = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic       rst;
    logic       req_valid, req_rw;
    logic [7:0] req_addr, req_wdata;
    logic       req_ready, rsp_valid, busy, mem_run, mem_rw;
    logic [7:0] rsp_rdata, mem_addr;
    wire  [7:0] uni_bus;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    assign uni_bus = tb_oe ? tb_dout : 8'hzz;

    // Second instance signals
    logic       rst3;
    logic       r3_valid, r3_rw;
    logic [7:0] r3_addr, r3_wdata;
    logic       r3_ready, r3_rsp_valid, r3_busy, r3_run, r3_mrw;
    logic [7:0] r3_rdata, r3_maddr;
    wire  [7:0] uni_bus3;
    logic       tb3_oe = 1'b0;
    logic [7:0] tb3_dout = 8'h00;
    assign uni_bus3 = tb3_oe ? tb3_dout : 8'hzz;

`ifdef MEM_BUS_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt, r3_stat_rd, r3_stat_wr;
`endif

    mem_bus_master #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .READ_LATENCY (RL)
    ) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_run   (mem_run),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
`ifdef MEM_BUS_STATS_EN
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt),
`endif
        .uniBus    (uni_bus)
    );

    mem_bus_master #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .READ_LATENCY (RL3)
    ) u_dut3 (
        .CLK       (clk),
        .RST       (rst3),
        .req_valid (r3_valid),
        .req_ready (r3_ready),
        .req_rw    (r3_rw),
        .req_addr  (r3_addr),
        .req_wdata (r3_wdata),
        .rsp_valid (r3_rsp_valid),
        .rsp_rdata (r3_rdata),
        .busy      (r3_busy),
        .mem_run   (r3_run),
        .mem_rw    (r3_mrw),
        .mem_addr  (r3_maddr),
`ifdef MEM_BUS_STATS_EN
        .stat_rd_cnt (r3_stat_rd),
        .stat_wr_cnt (r3_stat_wr),
`endif
        .uniBus    (uni_bus3)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    int unsigned n_rd   = 0;
    int unsigned n_wr   = 0;
    logic [7:0]  last_wdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic        rw;
        logic [7:0]  rdata;
        int unsigned cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Monitor: every response pulse must match the oldest expectation in cycle and data.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid with rdata %0h, expected none", rsp_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_cycle", mon_e.cyc, cyc);
                if (mon_e.rw == RW_READ) check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
            end
        end
    end

    // Memory responder model plus bus ownership checks on uniBus.
    logic [7:0]  mem [256];
    int unsigned rd_cnt = 0;
    logic [7:0]  rd_data = 8'h00;
    logic        is_wcmd = 1'b0;
    logic        whold_n = 1'b0;
    logic        probe = 1'b0;

    always begin
        @(negedge clk);
        tb_oe = 1'b0;
        probe = 1'b0;
        if (rst) rd_cnt = 0;
        if (rd_cnt != 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                tb_oe   = 1'b1;
                tb_dout = rd_data;
            end
        end
        if (mem_run === 1'b1 && mem_rw === RW_READ) begin
            rd_cnt  = RL;
            rd_data = mem[mem_addr];
        end
        is_wcmd = (mem_run === 1'b1) && (mem_rw === RW_WRITE);
        // Whenever the master should not be driving and memory is idle, drive a probe value;
        // any master drive would corrupt it.
        if (!tb_oe && !is_wcmd && !whold_n) begin
            probe   = 1'b1;
            tb_oe   = 1'b1;
            tb_dout = PROBE;
        end
        #1;
        if (tb_oe) check(probe ? "bus_master_float" : "bus_mem_drive", 32'(uni_bus), 32'(tb_dout));
        if (is_wcmd)  check("bus_wdata_cmd", 32'(uni_bus), 32'(last_wdata));
        if (whold_n)  check("bus_wdata_hold", 32'(uni_bus), 32'(last_wdata));
        if (is_wcmd) mem[mem_addr] = uni_bus;
        whold_n = is_wcmd;
        if (probe) tb_oe = 1'b0;
    end

    // Present a request at a negedge and hold it until accepted; returns at the next negedge.
    task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rd, output int unsigned acc_cyc);
        int unsigned waited;
        exp_t e;
        waited    = 0;
        acc_cyc   = 0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        while (req_ready !== 1'b1) begin
            if (waited == 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got no req_ready in 50 cycles, expected accept");
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        acc_cyc = cyc;
        e.rw    = rw;
        e.rdata = exp_rd;
        e.cyc   = cyc + ((rw == RW_READ) ? (2 + RL) : 2);
        sb_q.push_back(e);
        if (rw == RW_READ) n_rd++;
        else begin
            n_wr++;
            last_wdata = wdata;
        end
        @(negedge clk);
        // Scramble fields after accept; the master must ignore them while busy.
        req_valid = 1'b0;
        req_rw    = ~rw;
        req_addr  = ~addr;
        req_wdata = ~wdata;
    endtask

    int unsigned acc, acc_r, acc_w, guard;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;  req_valid = 1'b0; req_rw = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rst3 = 1'b1; r3_valid = 1'b0;  r3_rw = 1'b0;  r3_addr = 8'h00;  r3_wdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11;

        // Reset for two edges
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(1'b1));
        check("rst_busy",      32'(busy),      32'(1'b0));
        check("rst_mem_run",   32'(mem_run),   32'(1'b0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("rst_mem_rw",    32'(mem_rw),    32'(RW_READ));
        check("rst_mem_addr",  32'(mem_addr),  32'h00);
        rst = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // Write 3C <- A5
        issue(RW_WRITE, 8'h3C, 8'hA5, 8'h00, acc);
        check("wr_cmd_mem_run",  32'(mem_run),  32'(1'b1));
        check("wr_cmd_mem_rw",   32'(mem_rw),   32'(RW_WRITE));
        check("wr_cmd_mem_addr", 32'(mem_addr), 32'h3C);
        check("wr_cmd_busy",     32'(busy),     32'(1'b1));
        @(negedge clk);
        check("wr_hold_mem_run", 32'(mem_run),   32'(1'b0));
        check("wr_hold_ready",   32'(req_ready), 32'(1'b0));
        @(negedge clk);
        check("wr_done_ready",   32'(req_ready), 32'(1'b1));

        // Read 3C -> A5
        issue(RW_READ, 8'h3C, 8'h00, 8'hA5, acc);
        check("rd_cmd_mem_run",  32'(mem_run),  32'(1'b1));
        check("rd_cmd_mem_rw",   32'(mem_rw),   32'(RW_READ));
        check("rd_cmd_mem_addr", 32'(mem_addr), 32'h3C);

        // Back-to-back: read 00 (-> 11), write FF <- 5A queued behind it
        issue(RW_READ, 8'h00, 8'h00, 8'h11, acc_r);
        issue(RW_WRITE, 8'hFF, 8'h5A, 8'h00, acc_w);
        check("b2b_accept_gap", acc_w - acc_r, 3 + RL);
        check("b2b_wr_addr", 32'(mem_addr), 32'hFF);

        // Another write, then read back the top address
        issue(RW_WRITE, 8'h01, 8'hC3, 8'h00, acc);
        issue(RW_READ, 8'hFF, 8'h00, 8'h5A, acc);

        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("sb_drained", sb_q.size(), 0);
        repeat (2) @(negedge clk);
`ifdef MEM_BUS_STATS_EN
        check("stat_wr_cnt", 32'(stat_wr_cnt), n_wr);
        check("stat_rd_cnt", 32'(stat_rd_cnt), n_rd);
`endif

        // Reset during RWAIT on the READ_LATENCY=3 instance
        r3_valid = 1'b1;
        r3_rw    = RW_READ;
        r3_addr  = 8'h10;
        guard    = 0;
        while (r3_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("r3_ready_before", 32'(r3_ready), 32'(1'b1));
        @(negedge clk);
        r3_valid = 1'b0;
        check("r3_cmd_run", 32'(r3_run), 32'(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        check("r3_rst_ready",     32'(r3_ready),     32'(1'b1));
        check("r3_rst_busy",      32'(r3_busy),      32'(1'b0));
        check("r3_rst_run",       32'(r3_run),       32'(1'b0));
        check("r3_rst_rsp_valid", 32'(r3_rsp_valid), 32'(1'b0));
        check("r3_rst_rdata",     32'(r3_rdata),     32'h00);
        tb3_oe   = 1'b1;
        tb3_dout = PROBE;
        #1;
        check("r3_rst_bus_float", 32'(uni_bus3), 32'(PROBE));
        tb3_oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("r3_no_rsp", 32'(r3_rsp_valid), 32'(1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
